// File: rtl/alu_seq_n_bits_if.sv
// Valid/ready bundle between decode, the sequential ALU and writeback.
// master = producer/consumer side, slave = the ALU itself.
interface alu_seq_n_bits_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] RESULT;
  logic [3:0]   flags;
  logic         busy;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, RESULT, flags, busy
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, RESULT, flags, busy
  );
endinterface

// File: rtl/alu_seq_n_bits.sv
// Sequential N-bit ALU with valid/ready handshake, registered outputs and
// iterative MUL/UDIV/UREM sharing one shift datapath (one bit per cycle).
module alu_seq_n_bits #(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_seq_n_bits_if.slave  bus
);
  localparam int SHW = $clog2(N);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_ASL  = 4'b0110;
  localparam logic [3:0] OP_ASR  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b1000;
  localparam logic [3:0] OP_LSR  = 4'b1001;
  localparam logic [3:0] OP_MOV  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;
  localparam logic [3:0] OP_UDIV = 4'b1100;
  localparam logic [3:0] OP_UREM = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_r;
  logic           in_ready_r;
  logic           out_valid_r;
  logic           busy_r;
  logic [N-1:0]   result_r;
  logic [3:0]     flags_r;
  logic [SHW-1:0] count_r;
  logic [3:0]     op_r;
  logic [N-1:0]   opa_r;
  logic [N-1:0]   opb_r;
  logic [2*N-1:0] mcand_r;
  logic [2*N-1:0] acc_r;
  logic [N:0]     rem_r;
  logic [N-1:0]   quo_r;

  logic [SHW-1:0] sh_s;
  logic [N:0]     add_s;
  logic [N:0]     sub_s;
  logic [N:0]     lsh_s;
  logic [N:0]     rsh_s;
  logic [N:0]     asr_s;
  logic           asl_v_s;
  logic           iter_op_s;
  logic           sc_illegal_s;
  logic           sc_c_s;
  logic           sc_v_s;
  logic [N-1:0]   sc_res_s;
  logic [3:0]     sc_flags_s;

  logic [2*N-1:0] mul_acc_s;
  logic [N:0]     rem_sh_s;
  logic [N:0]     rem_diff_s;
  logic           div_ge_s;
  logic [N:0]     rem_nxt_s;
  logic [N-1:0]   quo_nxt_s;
  logic           div_zero_s;
  logic           it_v_s;
  logic [N-1:0]   it_res_s;
  logic [3:0]     it_flags_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.RESULT    = result_r;
  assign bus.flags     = flags_r;
  assign bus.busy      = busy_r;

  // Single-cycle result and flags, evaluated from the live inputs for the accept edge
  always_comb begin
    sh_s  = bus.B[SHW-1:0];
    add_s = {1'b0, bus.A} + {1'b0, bus.B};
    sub_s = {1'b0, bus.A} + {1'b0, ~bus.B} + {{N{1'b0}}, 1'b1};
    // The extra bit below/above the operand catches the last bit shifted out
    lsh_s = {1'b0, bus.A} << sh_s;
    rsh_s = {bus.A, 1'b0} >> sh_s;
    asr_s = $signed({bus.A, 1'b0}) >>> sh_s;
    asl_v_s = 1'b0;
    for (int i = 1; i < N; i++) begin
      if ((i <= int'(sh_s)) && (bus.A[N-1-i] != bus.A[N-1])) begin
        asl_v_s = 1'b1;
      end else begin
        asl_v_s = asl_v_s;
      end
    end
    iter_op_s    = (bus.ALUControl == OP_MUL) || (bus.ALUControl == OP_UDIV) ||
                   (bus.ALUControl == OP_UREM);
    sc_illegal_s = 1'b0;
    sc_c_s       = 1'b0;
    sc_v_s       = 1'b0;
    sc_res_s     = {N{1'b0}};
    case (bus.ALUControl)
      OP_ADD: begin
        sc_res_s = add_s[N-1:0];
        sc_c_s   = add_s[N];
        sc_v_s   = (bus.A[N-1] == bus.B[N-1]) && (add_s[N-1] != bus.A[N-1]);
      end
      OP_SUB: begin
        sc_res_s = sub_s[N-1:0];
        sc_c_s   = sub_s[N];
        sc_v_s   = (bus.A[N-1] != bus.B[N-1]) && (sub_s[N-1] != bus.A[N-1]);
      end
      OP_AND: sc_res_s = bus.A & bus.B;
      OP_OR:  sc_res_s = bus.A | bus.B;
      OP_XOR: sc_res_s = bus.A ^ bus.B;
      OP_NOT: sc_res_s = ~bus.A;
      OP_ASL: begin
        sc_res_s = lsh_s[N-1:0];
        sc_c_s   = lsh_s[N];
        sc_v_s   = asl_v_s;
      end
      OP_ASR: begin
        sc_res_s = asr_s[N:1];
        sc_c_s   = asr_s[0];
      end
      OP_LSL: begin
        sc_res_s = lsh_s[N-1:0];
        sc_c_s   = lsh_s[N];
      end
      OP_LSR: begin
        sc_res_s = rsh_s[N:1];
        sc_c_s   = rsh_s[0];
      end
      OP_MOV:  sc_res_s = bus.A;
      default: sc_illegal_s = 1'b1;
    endcase
    if (sc_illegal_s) begin
      sc_flags_s = 4'b1000;
    end else begin
      sc_flags_s = {(sc_res_s == {N{1'b0}}), sc_res_s[N-1], sc_c_s, sc_v_s};
    end
  end

  // One shift-add / restoring-divide step plus the final iterative result
  always_comb begin
    mul_acc_s  = acc_r + (opb_r[0] ? mcand_r : {(2*N){1'b0}});
    rem_sh_s   = {rem_r[N-1:0], quo_r[N-1]};
    rem_diff_s = rem_sh_s - {1'b0, opb_r};
    div_ge_s   = ~rem_diff_s[N];
    rem_nxt_s  = div_ge_s ? rem_diff_s : rem_sh_s;
    quo_nxt_s  = {quo_r[N-2:0], div_ge_s};
    div_zero_s = (opb_r == {N{1'b0}});
    it_v_s     = 1'b0;
    it_res_s   = {N{1'b0}};
    case (op_r)
      OP_MUL: begin
        it_res_s = mul_acc_s[N-1:0];
        it_v_s   = |mul_acc_s[2*N-1:N];
      end
      OP_UDIV: begin
        it_res_s = div_zero_s ? {N{1'b1}} : quo_nxt_s;
        it_v_s   = div_zero_s;
      end
      OP_UREM: begin
        it_res_s = div_zero_s ? opa_r : rem_nxt_s[N-1:0];
        it_v_s   = div_zero_s;
      end
      default: begin
        it_res_s = {N{1'b0}};
        it_v_s   = 1'b0;
      end
    endcase
    it_flags_s = {(it_res_s == {N{1'b0}}), it_res_s[N-1], 1'b0, it_v_s};
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= {N{1'b0}};
      flags_r     <= 4'b0000;
      count_r     <= {SHW{1'b0}};
      op_r        <= 4'b0000;
      opa_r       <= {N{1'b0}};
      opb_r       <= {N{1'b0}};
      mcand_r     <= {(2*N){1'b0}};
      acc_r       <= {(2*N){1'b0}};
      rem_r       <= {(N+1){1'b0}};
      quo_r       <= {N{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            op_r       <= bus.ALUControl;
            opa_r      <= bus.A;
            opb_r      <= bus.B;
            mcand_r    <= {{N{1'b0}}, bus.A};
            acc_r      <= {(2*N){1'b0}};
            rem_r      <= {(N+1){1'b0}};
            quo_r      <= bus.A;
            count_r    <= {SHW{1'b0}};
            in_ready_r <= 1'b0;
            if (iter_op_s) begin
              state_r <= BUSY;
              busy_r  <= 1'b1;
            end else begin
              state_r     <= DONE;
              result_r    <= sc_res_s;
              flags_r     <= sc_flags_s;
              out_valid_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        BUSY: begin
          acc_r   <= mul_acc_s;
          mcand_r <= mcand_r << 1;
          rem_r   <= rem_nxt_s;
          quo_r   <= quo_nxt_s;
          count_r <= count_r + {{(SHW-1){1'b0}}, 1'b1};
          // The divisor must stay put; only the multiplier is consumed bit by bit
          if (op_r == OP_MUL) begin
            opb_r <= opb_r >> 1;
          end
          if (count_r == SHW'(N-1)) begin
            state_r     <= DONE;
            busy_r      <= 1'b0;
            result_r    <= it_res_s;
            flags_r     <= it_flags_s;
            out_valid_r <= 1'b1;
            count_r     <= {SHW{1'b0}};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_n_bits.sv
// Bench for alu_seq_n_bits: an N=8 and an N=32 instance driven in lockstep,
// checked against an arithmetic reference model and a small table of known answers.
module tb_alu_seq_n_bits;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a_v;
  logic [31:0] b_v;
  logic [3:0]  op_v;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] r;
    logic [3:0] f;
    int         hold;
    bit         early;
  } vec_t;

  alu_seq_n_bits_if #(.N(8))  bus8 ();
  alu_seq_n_bits_if #(.N(32)) bus32 ();

  assign bus8.in_valid    = in_valid;
  assign bus8.A           = a_v[7:0];
  assign bus8.B           = b_v[7:0];
  assign bus8.ALUControl  = op_v;
  assign bus8.out_ready   = out_ready;
  assign bus32.in_valid   = in_valid;
  assign bus32.A          = a_v;
  assign bus32.B          = b_v;
  assign bus32.ALUControl = op_v;
  assign bus32.out_ready  = out_ready;

  alu_seq_n_bits #(.N(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  alu_seq_n_bits #(.N(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on n-bit values
  function automatic void model(input int n, input logic [31:0] a_in, input logic [31:0] b_in,
                                input logic [3:0] op, output logic [31:0] res,
                                output logic [3:0] fl);
    longint unsigned mask, a, b, r, p;
    longint sa, sb, s, lim;
    int sh;
    bit c, v, bad;
    mask = (64'd1 << n) - 64'd1;
    a    = longint'(a_in) & mask;
    b    = longint'(b_in) & mask;
    lim  = longint'(64'd1 << (n - 1));
    sa   = (((a >> (n - 1)) & 64'd1) != 64'd0) ? longint'(a) - 2 * lim : longint'(a);
    sb   = (((b >> (n - 1)) & 64'd1) != 64'd0) ? longint'(b) - 2 * lim : longint'(b);
    sh   = int'(b % longint'(n));
    c = 1'b0; v = 1'b0; bad = 1'b0; r = 64'd0;
    case (op)
      4'd0: begin
        r = a + b; c = ((r >> n) & 64'd1) != 64'd0;
        s = sa + sb; v = (s >= lim) || (s < -lim);
      end
      4'd1: begin
        r = a - b; c = (a >= b);
        s = sa - sb; v = (s >= lim) || (s < -lim);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6, 4'd8: begin
        r = a << sh;
        c = (sh != 0) && (((a >> (n - sh)) & 64'd1) != 64'd0);
        s = sa * (longint'(1) << sh);
        v = (op == 4'd6) && ((s >= lim) || (s < -lim));
      end
      4'd7, 4'd9: begin
        r = (op == 4'd7) ? longint'(sa >>> sh) : (a >> sh);
        c = (sh != 0) && (((a >> (sh - 1)) & 64'd1) != 64'd0);
      end
      4'd10: r = a;
      4'd11: begin
        p = a * b; r = p; v = (p >> n) != 64'd0;
      end
      4'd12: begin
        v = (b == 64'd0); r = v ? mask : a / b;
      end
      4'd13: begin
        v = (b == 64'd0); r = v ? a : a % b;
      end
      default: bad = 1'b1;
    endcase
    r   = r & mask;
    res = r[31:0];
    fl  = bad ? 4'b1000 : {(r == 64'd0), ((r >> (n - 1)) & 64'd1) != 64'd0, c, v};
  endfunction

  // One transaction on both instances; called at a negedge with both idle
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input int hold, input bit early, input bit use_tbl,
                        input logic [7:0] t_res, input logic [3:0] t_fl);
    logic [31:0] e8r, e32r, r8, r32;
    logic [3:0]  e8f, e32f, f8, f32;
    int          k8, k32, lat;
    bit          got8, got32, iter;
    model(8, a, b, op, e8r, e8f);
    model(32, a, b, op, e32r, e32f);
    if (use_tbl) begin
      e8r = {24'd0, t_res};
      e8f = t_fl;
    end
    iter = (op == 4'b1011) || (op == 4'b1100) || (op == 4'b1101);
    check("in_ready8_idle", bus8.in_ready, 64'd1);
    check("in_ready32_idle", bus32.in_ready, 64'd1);
    in_valid = 1'b1; a_v = a; b_v = b; op_v = op; out_ready = early;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a_v = $urandom; b_v = $urandom; op_v = 4'($urandom);
    @(negedge clk);
    if (iter) begin
      check("busy8", bus8.busy, 64'd1);
      check("busy32", bus32.busy, 64'd1);
    end
    got8 = 1'b0; got32 = 1'b0; k8 = -1; k32 = -1;
    r8 = 32'd0; r32 = 32'd0; f8 = 4'd0; f32 = 4'd0;
    for (int k = 0; (k < 64) && !(got8 && got32); k++) begin
      if (!got8 && bus8.out_valid) begin
        got8 = 1'b1; k8 = k; r8 = {24'd0, bus8.RESULT}; f8 = bus8.flags;
      end
      if (!got32 && bus32.out_valid) begin
        got32 = 1'b1; k32 = k; r32 = bus32.RESULT; f32 = bus32.flags;
      end
      if (!(got8 && got32)) @(negedge clk);
    end
    lat = iter ? 8 : 0;
    check($sformatf("lat8 op%0d", op), 64'(k8), 64'(lat));
    lat = iter ? 32 : 0;
    check($sformatf("lat32 op%0d", op), 64'(k32), 64'(lat));
    check($sformatf("res8 op%0d a=%0h b=%0h", op, a[7:0], b[7:0]), r8, e8r);
    check($sformatf("flags8 op%0d a=%0h b=%0h", op, a[7:0], b[7:0]), f8, e8f);
    check($sformatf("res32 op%0d a=%0h b=%0h", op, a, b), r32, e32r);
    check($sformatf("flags32 op%0d a=%0h b=%0h", op, a, b), f32, e32f);
    if (!early) begin
      check("in_ready8_done", bus8.in_ready, 64'd0);
      check("in_ready32_done", bus32.in_ready, 64'd0);
      // A request offered while DONE must be ignored
      in_valid = 1'b1;
      repeat (hold) @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid8", bus8.out_valid, 64'd1);
      check("hold_res8", bus8.RESULT, e8r);
      check("hold_flags8", bus8.flags, e8f);
      check("hold_valid32", bus32.out_valid, 64'd1);
      check("hold_res32", bus32.RESULT, e32r);
      check("hold_flags32", bus32.flags, e32f);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("drop_valid8", bus8.out_valid, 64'd0);
    check("drop_valid32", bus32.out_valid, 64'd0);
    check("back_ready8", bus8.in_ready, 64'd1);
    check("back_ready32", bus32.in_ready, 64'd1);
  endtask

  vec_t tbl[14];

  initial begin
    tbl = '{
      '{8'h7F, 8'h01, 4'b0000, 8'h80, 4'b0101, 5, 1'b0},
      '{8'h05, 8'h05, 4'b0001, 8'h00, 4'b1010, 0, 1'b1},
      '{8'h81, 8'h01, 4'b1001, 8'h40, 4'b0010, 1, 1'b0},
      '{8'h80, 8'h03, 4'b0111, 8'hF0, 4'b0100, 0, 1'b0},
      '{8'h80, 8'h00, 4'b0111, 8'h80, 4'b0100, 2, 1'b0},
      '{8'h10, 8'h11, 4'b1011, 8'h10, 4'b0001, 0, 1'b0},
      '{8'h03, 8'h05, 4'b1011, 8'h0F, 4'b0000, 0, 1'b1},
      '{8'd100, 8'd7, 4'b1100, 8'd14, 4'b0000, 3, 1'b0},
      '{8'd100, 8'd7, 4'b1101, 8'd2, 4'b0000, 0, 1'b0},
      '{8'd9, 8'd0, 4'b1100, 8'hFF, 4'b0101, 0, 1'b0},
      '{8'd9, 8'd0, 4'b1101, 8'd9, 4'b0001, 0, 1'b1},
      '{8'h12, 8'h34, 4'b1110, 8'h00, 4'b1000, 0, 1'b0},
      '{8'h40, 8'h01, 4'b0110, 8'h80, 4'b0101, 0, 1'b0},
      '{8'h81, 8'h01, 4'b1000, 8'h02, 4'b0010, 0, 1'b0}
    };
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_v = 32'd0; b_v = 32'd0; op_v = 4'd0;
    repeat (2) @(negedge clk);
    check("rst_result8", bus8.RESULT, 64'd0);
    check("rst_flags8", bus8.flags, 64'd0);
    check("rst_valid8", bus8.out_valid, 64'd0);
    check("rst_busy8", bus8.busy, 64'd0);
    check("rst_ready8", bus8.in_ready, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready8", bus8.in_ready, 64'd1);
    check("post_rst_ready32", bus32.in_ready, 64'd1);

    foreach (tbl[i]) begin
      run_op({24'd0, tbl[i].a}, {24'd0, tbl[i].b}, tbl[i].op, tbl[i].hold, tbl[i].early,
             1'b1, tbl[i].r, tbl[i].f);
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_op(ra, rb, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'b0, 8'd0, 4'd0);
    end

    // Reset in the middle of a multiply aborts it
    in_valid = 1'b1; a_v = 32'd3; b_v = 32'd5; op_v = 4'b1011; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy8", bus8.busy, 64'd0);
    check("abort_valid8", bus8.out_valid, 64'd0);
    check("abort_result8", bus8.RESULT, 64'd0);
    check("abort_flags8", bus8.flags, 64'd0);
    check("abort_result32", bus32.RESULT, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready8", bus8.in_ready, 64'd1);
    check("abort_ready32", bus32.in_ready, 64'd1);
    repeat (10) @(negedge clk);
    check("abort_no_result8", bus8.out_valid, 64'd0);
    check("abort_no_result32", bus32.out_valid, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
